// File: rtl/axi_sspi_mem_if.sv
// AXI4 slave-side bundle for the SPI-slave scratch memory (axi_sspi_mem).
// The master modport is the SPI-slave wrapper side; the slave modport is the memory side.
interface axi_sspi_mem_if #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 3
);
   logic                          s_aw_valid;
   logic                          s_aw_ready;
   logic [AXI_ADDR_WIDTH-1:0]     s_aw_addr;
   logic [7:0]                    s_aw_len;
   logic [2:0]                    s_aw_size;
   logic [1:0]                    s_aw_burst;
   logic [AXI_ID_WIDTH-1:0]       s_aw_id;

   logic                          s_w_valid;
   logic                          s_w_ready;
   logic [AXI_DATA_WIDTH-1:0]     s_w_data;
   logic [AXI_DATA_WIDTH/8-1:0]   s_w_strb;
   logic                          s_w_last;

   logic                          s_b_valid;
   logic                          s_b_ready;
   logic [1:0]                    s_b_resp;
   logic [AXI_ID_WIDTH-1:0]       s_b_id;

   logic                          s_ar_valid;
   logic                          s_ar_ready;
   logic [AXI_ADDR_WIDTH-1:0]     s_ar_addr;
   logic [7:0]                    s_ar_len;
   logic [2:0]                    s_ar_size;
   logic [1:0]                    s_ar_burst;
   logic [AXI_ID_WIDTH-1:0]       s_ar_id;

   logic                          s_r_valid;
   logic                          s_r_ready;
   logic [AXI_DATA_WIDTH-1:0]     s_r_data;
   logic [1:0]                    s_r_resp;
   logic                          s_r_last;
   logic [AXI_ID_WIDTH-1:0]       s_r_id;

   modport slave (
      input  s_aw_valid, s_aw_addr, s_aw_len, s_aw_size, s_aw_burst, s_aw_id,
      output s_aw_ready,
      input  s_w_valid, s_w_data, s_w_strb, s_w_last,
      output s_w_ready,
      output s_b_valid, s_b_resp, s_b_id,
      input  s_b_ready,
      input  s_ar_valid, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, s_ar_id,
      output s_ar_ready,
      output s_r_valid, s_r_data, s_r_resp, s_r_last, s_r_id,
      input  s_r_ready
   );

   modport master (
      output s_aw_valid, s_aw_addr, s_aw_len, s_aw_size, s_aw_burst, s_aw_id,
      input  s_aw_ready,
      output s_w_valid, s_w_data, s_w_strb, s_w_last,
      input  s_w_ready,
      input  s_b_valid, s_b_resp, s_b_id,
      output s_b_ready,
      output s_ar_valid, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, s_ar_id,
      input  s_ar_ready,
      input  s_r_valid, s_r_data, s_r_resp, s_r_last, s_r_id,
      output s_r_ready
   );
endinterface

// File: rtl/axi_sspi_mem.sv
// AXI4 slave scratch memory behind the SPI-slave AXI master port.
// Single-ported flop array, one burst in flight, FIXED/INCR/WRAP bursts.
// Optional build macro AXI_SSPI_MEM_RANGE_CHECK_EN: flag and suppress beats
// outside the memory window; without it, offsets wrap modulo MEM_DEPTH.
module axi_sspi_mem #(
   parameter int                          AXI_ADDR_WIDTH = 32,
   parameter int                          AXI_DATA_WIDTH = 64,
   parameter int                          AXI_ID_WIDTH   = 3,
   parameter int                          MEM_DEPTH      = 256,
   parameter logic [AXI_ADDR_WIDTH-1:0]   BASE_ADDR      = {AXI_ADDR_WIDTH{1'b0}}
) (
   input  logic             clk_i,
   input  logic             rst_i,
   axi_sspi_mem_if.slave    bus
);
   localparam int AW    = AXI_ADDR_WIDTH;
   localparam int DW    = AXI_DATA_WIDTH;
   localparam int IW    = AXI_ID_WIDTH;
   localparam int NB    = DW / 8;
   localparam int LOG2B = $clog2(NB);
   localparam int IDXW  = $clog2(MEM_DEPTH);

   localparam logic [2:0]    MAX_SIZE    = 3'(LOG2B);
   localparam logic [AW-1:0] ADDR_ONE    = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [1:0]    RESP_OKAY   = 2'b00;
   localparam logic [1:0]    RESP_SLVERR = 2'b10;
   localparam logic [1:0]    BURST_FIXED = 2'b00;
   localparam logic [1:0]    BURST_WRAP  = 2'b10;
   localparam logic [1:0]    BURST_RSVD  = 2'b11;

   localparam logic [1:0]    ST_IDLE  = 2'd0;
   localparam logic [1:0]    ST_WDATA = 2'd1;
   localparam logic [1:0]    ST_WRESP = 2'd2;
   localparam logic [1:0]    ST_RDATA = 2'd3;

   // WRAP is only legal for 2, 4, 8 or 16 beats
   function automatic logic wrap_len_ok(input logic [7:0] len);
      wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

   // Error causes that hold for every beat of the burst
   function automatic logic burst_err(input logic [7:0] len, input logic [2:0] size,
                                      input logic [1:0] burst);
      burst_err = (size > MAX_SIZE) || (burst == BURST_RSVD) ||
                  ((burst == BURST_WRAP) && !wrap_len_ok(len));
   endfunction

   // Address of the following beat; an illegal WRAP just steps like INCR
   function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [7:0] len,
                                               input logic [2:0] size, input logic [1:0] burst);
      logic [AW-1:0] step;
      logic [AW-1:0] wbytes;
      logic [AW-1:0] wmask;
      step   = ADDR_ONE << size;
      wbytes = ({{(AW-8){1'b0}}, len} + ADDR_ONE) << size;
      wmask  = wbytes - ADDR_ONE;
      case (burst)
         BURST_FIXED: next_addr = a;
         BURST_WRAP:  next_addr = wrap_len_ok(len) ? ((a & ~wmask) | ((a + step) & wmask))
                                                   : (a + step);
         default:     next_addr = a + step;
      endcase
   endfunction

   // Word index of a byte address; upper offset bits fold away (modulo depth)
   function automatic logic [IDXW-1:0] word_idx(input logic [AW-1:0] a);
      logic [AW-1:0] off;
      off      = a - BASE_ADDR;
      word_idx = IDXW'(off >> LOG2B);
   endfunction

`ifdef AXI_SSPI_MEM_RANGE_CHECK_EN
   // True when the byte address falls inside the memory window
   function automatic logic in_range(input logic [AW-1:0] a);
      logic [AW-1:0] off;
      off      = a - BASE_ADDR;
      in_range = off < AW'(MEM_DEPTH * NB);
   endfunction
`endif

   logic [DW-1:0]   mem_q [MEM_DEPTH];

   logic [1:0]      state_q, state_d;
   logic            wprio_q, wprio_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [7:0]      len_q, len_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [2:0]      size_q, size_d;
   logic [1:0]      burst_q, burst_d;
   logic [IW-1:0]   id_q, id_d;
   logic            err_q, err_d;
   logic            r_valid_q, r_valid_d;
   logic [DW-1:0]   r_data_q, r_data_d;
   logic [1:0]      r_resp_q, r_resp_d;
   logic            r_last_q, r_last_d;

   logic            aw_ready;
   logic            ar_ready;
   logic            w_ready;
   logic            mem_we;
   logic [IDXW-1:0] mem_widx;
   logic            wb_oor;
   logic [AW-1:0]   rb_addr;
   logic [7:0]      rb_len;
   logic [2:0]      rb_size;
   logic [1:0]      rb_burst;
   logic            rb_oor;
   logic [DW-1:0]   rb_data;
   logic [1:0]      rb_resp;
   logic [AW-1:0]   rb_next;

   // Fetch the read beat: from the AR payload when starting, else from the latched beat address
   always_comb begin
      if (state_q == ST_IDLE) begin
         rb_addr  = bus.s_ar_addr;
         rb_len   = bus.s_ar_len;
         rb_size  = bus.s_ar_size;
         rb_burst = bus.s_ar_burst;
      end else begin
         rb_addr  = addr_q;
         rb_len   = len_q;
         rb_size  = size_q;
         rb_burst = burst_q;
      end
`ifdef AXI_SSPI_MEM_RANGE_CHECK_EN
      rb_oor = !in_range(rb_addr);
      wb_oor = !in_range(addr_q);
`else
      rb_oor = 1'b0;
      wb_oor = 1'b0;
`endif
      if ((rb_size > MAX_SIZE) || rb_oor) begin
         rb_data = {DW{1'b0}};
      end else begin
         rb_data = mem_q[word_idx(rb_addr)];
      end
      rb_resp = (burst_err(rb_len, rb_size, rb_burst) || rb_oor) ? RESP_SLVERR : RESP_OKAY;
      rb_next = next_addr(rb_addr, rb_len, rb_size, rb_burst);
   end

   // Transaction FSM: arbitration, burst tracking, response generation
   always_comb begin
      state_d   = state_q;
      wprio_d   = wprio_q;
      addr_d    = addr_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      size_d    = size_q;
      burst_d   = burst_q;
      id_d      = id_q;
      err_d     = err_q;
      r_valid_d = r_valid_q;
      r_data_d  = r_data_q;
      r_resp_d  = r_resp_q;
      r_last_d  = r_last_q;
      aw_ready  = 1'b0;
      ar_ready  = 1'b0;
      w_ready   = 1'b0;
      mem_we    = 1'b0;
      mem_widx  = word_idx(addr_q);
      case (state_q)
         ST_IDLE: begin
            aw_ready = bus.s_aw_valid & (!bus.s_ar_valid | wprio_q) & !rst_i;
            ar_ready = bus.s_ar_valid & (!bus.s_aw_valid | !wprio_q) & !rst_i;
            if (aw_ready) begin
               addr_d  = bus.s_aw_addr;
               len_d   = bus.s_aw_len;
               size_d  = bus.s_aw_size;
               burst_d = bus.s_aw_burst;
               id_d    = bus.s_aw_id;
               cnt_d   = 8'd0;
               err_d   = burst_err(bus.s_aw_len, bus.s_aw_size, bus.s_aw_burst);
               wprio_d = !wprio_q;
               state_d = ST_WDATA;
            end else if (ar_ready) begin
               len_d     = bus.s_ar_len;
               size_d    = bus.s_ar_size;
               burst_d   = bus.s_ar_burst;
               id_d      = bus.s_ar_id;
               cnt_d     = 8'd0;
               addr_d    = rb_next;
               r_valid_d = 1'b1;
               r_data_d  = rb_data;
               r_resp_d  = rb_resp;
               r_last_d  = (bus.s_ar_len == 8'd0);
               wprio_d   = !wprio_q;
               state_d   = ST_RDATA;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WDATA: begin
            w_ready = !rst_i;
            if (bus.s_w_valid && w_ready) begin
               mem_we = !(size_q > MAX_SIZE) && !wb_oor;
               err_d  = err_q || wb_oor || (bus.s_w_last != (cnt_q == len_q));
               if (cnt_q == len_q) begin
                  state_d = ST_WRESP;
               end else begin
                  cnt_d  = cnt_q + 8'd1;
                  addr_d = next_addr(addr_q, len_q, size_q, burst_q);
               end
            end else begin
               state_d = ST_WDATA;
            end
         end
         ST_WRESP: begin
            if (bus.s_b_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WRESP;
            end
         end
         ST_RDATA: begin
            if (bus.s_r_ready) begin
               if (r_last_q) begin
                  r_valid_d = 1'b0;
                  r_last_d  = 1'b0;
                  state_d   = ST_IDLE;
               end else begin
                  cnt_d    = cnt_q + 8'd1;
                  addr_d   = rb_next;
                  r_data_d = rb_data;
                  r_resp_d = rb_resp;
                  r_last_d = ((cnt_q + 8'd1) == len_q);
               end
            end else begin
               state_d = ST_RDATA;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and response registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         wprio_q   <= 1'b1;
         addr_q    <= {AW{1'b0}};
         len_q     <= 8'd0;
         cnt_q     <= 8'd0;
         size_q    <= 3'd0;
         burst_q   <= 2'd0;
         id_q      <= {IW{1'b0}};
         err_q     <= 1'b0;
         r_valid_q <= 1'b0;
         r_data_q  <= {DW{1'b0}};
         r_resp_q  <= 2'd0;
         r_last_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         wprio_q   <= wprio_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         size_q    <= size_d;
         burst_q   <= burst_d;
         id_q      <= id_d;
         err_q     <= err_d;
         r_valid_q <= r_valid_d;
         r_data_q  <= r_data_d;
         r_resp_q  <= r_resp_d;
         r_last_q  <= r_last_d;
      end
   end

   // Byte-masked write port into the storage array (contents survive reset)
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int b = 0; b < NB; b++) begin
            if (bus.s_w_strb[b]) begin
               mem_q[mem_widx][8*b +: 8] <= bus.s_w_data[8*b +: 8];
            end
         end
      end
   end

   assign bus.s_aw_ready = aw_ready;
   assign bus.s_ar_ready = ar_ready;
   assign bus.s_w_ready  = w_ready;
   assign bus.s_b_valid  = (state_q == ST_WRESP);
   assign bus.s_b_resp   = err_q ? RESP_SLVERR : RESP_OKAY;
   assign bus.s_b_id     = id_q;
   assign bus.s_r_valid  = r_valid_q;
   assign bus.s_r_data   = r_data_q;
   assign bus.s_r_resp   = r_resp_q;
   assign bus.s_r_last   = r_last_q;
   assign bus.s_r_id     = id_q;
endmodule

// File: tb/tb_axi_sspi_mem.sv
// Directed self-checking bench for axi_sspi_mem (64-bit data, 256 words, base 0).
module tb_axi_sspi_mem;
   localparam int AW = 32;
   localparam int DW = 64;
   localparam int IW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axi_sspi_mem_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) bus ();

   axi_sspi_mem #(
      .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
      .MEM_DEPTH(256), .BASE_ADDR(32'h0)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] wdat  [16];
   logic [7:0]  wstb  [16];
   logic [63:0] rdat  [16];
   logic [1:0]  rresp [16];
   logic        rlast [16];
   logic [2:0]  rid;
   logic [1:0]  bresp;
   logic [2:0]  bid;
   int          b_wait;
   int          r_wait;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.s_aw_valid = 1'b0; bus.s_aw_addr = '0; bus.s_aw_len = '0;
      bus.s_aw_size = '0; bus.s_aw_burst = '0; bus.s_aw_id = '0;
      bus.s_w_valid = 1'b0; bus.s_w_data = '0; bus.s_w_strb = '0; bus.s_w_last = 1'b0;
      bus.s_b_ready = 1'b0;
      bus.s_ar_valid = 1'b0; bus.s_ar_addr = '0; bus.s_ar_len = '0;
      bus.s_ar_size = '0; bus.s_ar_burst = '0; bus.s_ar_id = '0;
      bus.s_r_ready = 1'b0;
   endtask

   task automatic set_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] sz,
                         input logic [1:0] bu, input logic [2:0] id);
      bus.s_aw_valid = 1'b1; bus.s_aw_addr = a; bus.s_aw_len = l;
      bus.s_aw_size = sz; bus.s_aw_burst = bu; bus.s_aw_id = id;
   endtask

   task automatic set_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] sz,
                         input logic [1:0] bu, input logic [2:0] id);
      bus.s_ar_valid = 1'b1; bus.s_ar_addr = a; bus.s_ar_len = l;
      bus.s_ar_size = sz; bus.s_ar_burst = bu; bus.s_ar_id = id;
   endtask

   task automatic drive_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] sz,
                           input logic [1:0] bu, input logic [2:0] id);
      int t;
      @(negedge clk);
      set_aw(a, l, sz, bu, id);
      t = 0;
      #1;
      while (!bus.s_aw_ready && t < 50) begin @(negedge clk); #1; t++; end
      if (!bus.s_aw_ready) check_val("aw_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      bus.s_aw_valid = 1'b0;
   endtask

   task automatic drive_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] sz,
                           input logic [1:0] bu, input logic [2:0] id);
      int t;
      @(negedge clk);
      set_ar(a, l, sz, bu, id);
      t = 0;
      #1;
      while (!bus.s_ar_ready && t < 50) begin @(negedge clk); #1; t++; end
      if (!bus.s_ar_ready) check_val("ar_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      bus.s_ar_valid = 1'b0;
   endtask

   // W beats from wdat/wstb; w_last is raised only on beat index last_at
   task automatic drive_w(input int nbeats, input int last_at);
      int t;
      for (int i = 0; i < nbeats; i++) begin
         @(negedge clk);
         bus.s_w_valid = 1'b1; bus.s_w_data = wdat[i]; bus.s_w_strb = wstb[i];
         bus.s_w_last = (i == last_at);
         t = 0;
         #1;
         while (!bus.s_w_ready && t < 50) begin @(negedge clk); #1; t++; end
         if (!bus.s_w_ready) check_val("w_timeout", 64'd0, 64'd1);
         @(posedge clk); #1;
      end
      bus.s_w_valid = 1'b0;
      bus.s_w_last  = 1'b0;
   endtask

   task automatic get_b();
      int t;
      bus.s_b_ready = 1'b1;
      t = 0;
      @(negedge clk);
      while (!bus.s_b_valid && t < 50) begin @(negedge clk); t++; end
      if (!bus.s_b_valid) check_val("b_timeout", 64'd0, 64'd1);
      b_wait = t; bresp = bus.s_b_resp; bid = bus.s_b_id;
      @(posedge clk); #1;
      bus.s_b_ready = 1'b0;
   endtask

   task automatic get_r(input int nbeats);
      int t;
      r_wait = 0;
      bus.s_r_ready = 1'b1;
      for (int i = 0; i < nbeats; i++) begin
         t = 0;
         @(negedge clk);
         while (!bus.s_r_valid && t < 50) begin @(negedge clk); t++; end
         if (!bus.s_r_valid) check_val("r_timeout", 64'd0, 64'd1);
         r_wait += t;
         rdat[i] = bus.s_r_data; rresp[i] = bus.s_r_resp; rlast[i] = bus.s_r_last;
         rid = bus.s_r_id;
         @(posedge clk); #1;
      end
      bus.s_r_ready = 1'b0;
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [7:0] l, input logic [2:0] sz,
                            input logic [1:0] bu, input logic [2:0] id, input int last_at);
      drive_aw(a, l, sz, bu, id);
      drive_w(int'(l) + 1, last_at);
      get_b();
   endtask

   task automatic axi_read(input logic [31:0] a, input logic [7:0] l, input logic [2:0] sz,
                           input logic [1:0] bu, input logic [2:0] id);
      drive_ar(a, l, sz, bu, id);
      get_r(int'(l) + 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] exp_w [4];
      idle_inputs();
      for (int i = 0; i < 16; i++) begin wdat[i] = 64'd0; wstb[i] = 8'hFF; end

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_w_ready", {63'd0, bus.s_w_ready}, 64'd0);
      check_val("rst_b_valid", {63'd0, bus.s_b_valid}, 64'd0);
      check_val("rst_r_valid", {63'd0, bus.s_r_valid}, 64'd0);
      check_val("rst_r_data", bus.s_r_data, 64'd0);
      check_val("rst_r_last", {63'd0, bus.s_r_last}, 64'd0);
      check_val("rst_b_id", {61'd0, bus.s_b_id}, 64'd0);
      rst = 1'b0;

      // arbitration: write first after reset, then read
      @(negedge clk);
      set_aw(32'h0, 8'd0, 3'd3, 2'b01, 3'd1);
      set_ar(32'h0, 8'd0, 3'd3, 2'b01, 3'd2);
      #1;
      check_val("arb1_aw_ready", {63'd0, bus.s_aw_ready}, 64'd1);
      check_val("arb1_ar_ready", {63'd0, bus.s_ar_ready}, 64'd0);
      @(posedge clk); #1;
      bus.s_aw_valid = 1'b0; bus.s_ar_valid = 1'b0;
      wdat[0] = 64'h1122334455667788; wstb[0] = 8'hFF;
      drive_w(1, 0);
      get_b();
      check_val("arb1_bresp", {62'd0, bresp}, 64'd0);
      check_val("arb1_bid", {61'd0, bid}, 64'd1);
      @(negedge clk);
      set_aw(32'h0, 8'd0, 3'd3, 2'b01, 3'd1);
      set_ar(32'h0, 8'd0, 3'd3, 2'b01, 3'd2);
      #1;
      check_val("arb2_aw_ready", {63'd0, bus.s_aw_ready}, 64'd0);
      check_val("arb2_ar_ready", {63'd0, bus.s_ar_ready}, 64'd1);
      @(posedge clk); #1;
      bus.s_aw_valid = 1'b0; bus.s_ar_valid = 1'b0;
      get_r(1);
      check_val("arb2_rdata", rdat[0], 64'h1122334455667788);
      check_val("arb2_rid", {61'd0, rid}, 64'd2);

      // INCR write then read back, with latency checks
      exp_w[0] = 64'h11; exp_w[1] = 64'h22; exp_w[2] = 64'h33; exp_w[3] = 64'h44;
      for (int i = 0; i < 4; i++) begin wdat[i] = exp_w[i]; wstb[i] = 8'hFF; end
      axi_write(32'h10, 8'd3, 3'd3, 2'b01, 3'd5, 3);
      check_val("incr_bresp", {62'd0, bresp}, 64'd0);
      check_val("incr_bid", {61'd0, bid}, 64'd5);
      check_val("incr_b_latency", b_wait, 64'd0);
      axi_read(32'h10, 8'd3, 3'd3, 2'b01, 3'd6);
      for (int i = 0; i < 4; i++) begin
         check_val($sformatf("incr_rdata%0d", i), rdat[i], exp_w[i]);
         check_val($sformatf("incr_rresp%0d", i), {62'd0, rresp[i]}, 64'd0);
         check_val($sformatf("incr_rlast%0d", i), {63'd0, rlast[i]}, (i == 3) ? 64'd1 : 64'd0);
      end
      check_val("incr_rid", {61'd0, rid}, 64'd6);
      check_val("incr_r_latency", r_wait, 64'd0);

      // narrow write of two bytes into lanes 3 and 4 of word 0
      wdat[0] = 64'h000000AABB000000; wstb[0] = 8'h18;
      axi_write(32'h3, 8'd0, 3'd1, 2'b01, 3'd3, 0);
      check_val("narrow_bresp", {62'd0, bresp}, 64'd0);
      axi_read(32'h0, 8'd0, 3'd3, 2'b01, 3'd3);
      check_val("narrow_rdata", rdat[0], 64'h112233AABB667788);

      // WRAP read: fill words 4..7 then read from 0x28
      for (int i = 0; i < 4; i++) begin wdat[i] = 64'hA0A0_0000_0000_0004 + 64'(i); wstb[i] = 8'hFF; end
      axi_write(32'h20, 8'd3, 3'd3, 2'b01, 3'd0, 3);
      axi_read(32'h28, 8'd3, 3'd3, 2'b10, 3'd4);
      check_val("wrap_beat0", rdat[0], 64'hA0A0_0000_0000_0005);
      check_val("wrap_beat1", rdat[1], 64'hA0A0_0000_0000_0006);
      check_val("wrap_beat2", rdat[2], 64'hA0A0_0000_0000_0007);
      check_val("wrap_beat3", rdat[3], 64'hA0A0_0000_0000_0004);
      check_val("wrap_last", {63'd0, rlast[3]}, 64'd1);
      check_val("wrap_resp", {62'd0, rresp[0]}, 64'd0);
      axi_read(32'h28, 8'd2, 3'd3, 2'b10, 3'd4);
      for (int i = 0; i < 3; i++) begin
         check_val($sformatf("badwrap_resp%0d", i), {62'd0, rresp[i]}, 64'd2);
      end
      check_val("badwrap_last", {63'd0, rlast[2]}, 64'd1);

      // w_last on the wrong beat: SLVERR, beat count still governs
      wdat[0] = 64'h6161; wdat[1] = 64'h6262; wstb[0] = 8'hFF; wstb[1] = 8'hFF;
      axi_write(32'h60, 8'd1, 3'd3, 2'b01, 3'd2, 0);
      check_val("wlast_bresp", {62'd0, bresp}, 64'd2);
      axi_read(32'h60, 8'd1, 3'd3, 2'b01, 3'd2);
      check_val("wlast_rdata1", rdat[1], 64'h6262);

      // oversize beat: write dropped, read returns zero with SLVERR
      wdat[0] = 64'hFFFF; wstb[0] = 8'hFF;
      axi_write(32'h60, 8'd0, 3'd4, 2'b01, 3'd1, 0);
      check_val("size_bresp", {62'd0, bresp}, 64'd2);
      axi_read(32'h60, 8'd0, 3'd4, 2'b01, 3'd1);
      check_val("size_rdata", rdat[0], 64'd0);
      check_val("size_rresp", {62'd0, rresp[0]}, 64'd2);

      // write just past the memory window
      wdat[0] = 64'hDEADBEEF00000005; wstb[0] = 8'hFF;
      axi_write(32'h800, 8'd0, 3'd3, 2'b01, 3'd7, 0);
      axi_read(32'h0, 8'd0, 3'd3, 2'b01, 3'd7);
`ifdef AXI_SSPI_MEM_RANGE_CHECK_EN
      check_val("range_bresp", {62'd0, bresp}, 64'd2);
      check_val("range_word0", rdat[0], 64'h112233AABB667788);
`else
      check_val("range_bresp", {62'd0, bresp}, 64'd0);
      check_val("range_word0", rdat[0], 64'hDEADBEEF00000005);
`endif

      // reset in the middle of a 4-beat write
      wdat[0] = 64'hCAFE000000000001; wstb[0] = 8'hFF;
      drive_aw(32'h40, 8'd3, 3'd3, 2'b01, 3'd4);
      drive_w(1, 3);
      @(negedge clk);
      rst = 1'b1;
      bus.s_w_valid = 1'b1; bus.s_w_data = 64'hCAFE000000000002; bus.s_w_strb = 8'hFF;
      @(negedge clk);
      check_val("abort_w_ready", {63'd0, bus.s_w_ready}, 64'd0);
      check_val("abort_b_valid", {63'd0, bus.s_b_valid}, 64'd0);
      bus.s_w_valid = 1'b0;
      rst = 1'b0;
      bus.s_b_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_val("abort_no_b", {63'd0, bus.s_b_valid}, 64'd0);
      end
      bus.s_b_ready = 1'b0;
      axi_read(32'h40, 8'd0, 3'd3, 2'b01, 3'd1);
      check_val("abort_partial", rdat[0], 64'hCAFE000000000001);
      wdat[0] = 64'h5555AAAA5555AAAA; wstb[0] = 8'hFF;
      axi_write(32'h40, 8'd0, 3'd3, 2'b01, 3'd6, 0);
      check_val("fresh_bresp", {62'd0, bresp}, 64'd0);
      check_val("fresh_bid", {61'd0, bid}, 64'd6);
      axi_read(32'h40, 8'd0, 3'd3, 2'b01, 3'd1);
      check_val("fresh_rdata", rdat[0], 64'h5555AAAA5555AAAA);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
